amber_wb_arbiter: RTL and testbench
===================================

// Module: amber_wb_arbiter
// PURPOSE
//  Two-master Wishbone arbiter. Shares the Amber core's single 128-bit Wishbone slave port between
//  master 0 (Amber core fetch/data port) and master 1 (bench preload / debug loader).
//  Ownership is per-bus-cycle: it is held while the owner keeps cyc high, with round-robin on contention.
//  Sits between the core's o_wb_*/i_wb_* pins and the memory model.
// PARAMETERS
//  ADDR_W          32   address width
//  DATA_W          128  data width; SEL_W = DATA_W/8 (16)
//  TIMEOUT_CYCLES  64   watchdog limit in cycles of stb without ack/err (only used with AMBER_WB_ARB_TIMEOUT_EN)
// PORTS
//  clk            in   1       system clock, all flops on posedge
//  rst            in   1       asynchronous, active-high reset
//  mN_adr         in   ADDR_W  master N address (N = 0,1; likewise below)
//  mN_sel         in   SEL_W   master N byte selects
//  mN_we          in   1       master N write enable
//  mN_dat_w       in   DATA_W  master N write data
//  mN_cyc         in   1       master N bus-cycle request
//  mN_stb         in   1       master N strobe
//  mN_dat_r       out  DATA_W  read data to master N (= s_dat_r, unqualified)
//  mN_ack         out  1       ack to master N, only while N owns the bus
//  mN_err         out  1       err to master N, only while N owns the bus
//  s_adr/s_sel/s_we/s_dat_w/s_cyc/s_stb  out  as above  muxed request to the slave
//  s_dat_r        in   DATA_W  slave read data
//  s_ack          in   1       slave ack
//  s_err          in   1       slave err
//  gnt            out  2       one-hot current owner (bit N = master N), 0 when idle
// BEHAVIOUR
//  - FSM arb_state_t: ARB_IDLE, ARB_GNT0, ARB_GNT1. Registered state plus last_gnt (1 bit).
//  - Reset: state=ARB_IDLE, last_gnt=1 (m0 wins first contention), gnt=0, watchdog count=0.
//  - ARB_IDLE: all s_* outputs drive 0. Both mN_ack and mN_err are 0.
//  - ARB_IDLE transitions:
//      m0_cyc only -> ARB_GNT0.   m1_cyc only -> ARB_GNT1.
//      Both -> grant the master != last_gnt.   Neither -> stay.
//  - Grant latency: 1 cycle from cyc rising to s_cyc. The new owner's s_stb is visible that same cycle.
//  - ARB_GNTn: s_* = mN_* combinationally. mN_ack=s_ack, mN_err=s_err. The other master's ack/err = 0.
//  - Leaving ARB_GNTn: mN_cyc low -> ARB_IDLE and last_gnt=N. Exactly one idle cycle separates owners.
//  - Owner drops cyc before ack (abort): the grant is released. A late s_ack/s_err in ARB_IDLE is discarded.
//  - Non-owner requests are stalled (no ack) indefinitely; there is no preemption mid-cycle.
//  - s_ack and s_err both high: pass both through; the master treats err as dominant.
//  - Reset asserted mid-cycle: state returns to ARB_IDLE immediately (async). s_cyc/s_stb drop the same instant.
// CONFIGURATION
//  - `AMBER_WB_ARB_TIMEOUT_EN defined: the watchdog counts cycles with s_stb=1 & !s_ack & !s_err.
//      The count clears on ack, err, stb low or owner change.
//      When count == TIMEOUT_CYCLES-1, for one cycle: the arbiter asserts the owner's mN_err and forces s_cyc=s_stb=0,
//        then moves to ARB_IDLE with last_gnt=N. s_ack in that cycle is discarded.
//      Count width is $clog2(TIMEOUT_CYCLES+1) and saturates, so it never wraps.
//  - Undefined: no counter is present. A hung slave stalls the owner forever.
//    The error path is driven by s_err only.
// STRUCTURE
//  - amber_wb_arb_pkg: arb_state_t enum, default ADDR_W/DATA_W/TIMEOUT_CYCLES localparams, SEL_W function.
//  - Sub-module amber_wb_watchdog (clk, rst, clr, busy -> expire), instantiated only under the macro.
//  - Top level: FSM, last_gnt flop, request mux, response demux.
// TESTING
//  1. Reset, then m0 single read adr=0x100: s_cyc rises 1 cycle after m0_cyc, s_ack=1 -> m0_ack=1, m1_ack=0, gnt=2'b01.
//  2. m0_cyc and m1_cyc rise together after reset -> gnt=01. m0 drops cyc -> 1 idle cycle -> gnt=10.
//  3. m1 owns with a 4-beat burst (cyc held) while m0 requests -> all 4 acks go to m1, m0 stalled; then m0 granted.
//  4. m1 aborts (cyc low) before ack; slave acks 1 cycle later -> gnt=00, m0_ack=m1_ack=0.
//  5. m0 write dat=128'hDEAD...BEEF, sel=16'hFFFF: s_we=1, s_dat_w matches the value with the selected byte lanes.
//  6. Macro on, TIMEOUT_CYCLES=8, slave never acks -> m0_err pulses 1 cycle on the 8th stb cycle, s_cyc=0, gnt=00.
//     Macro off -> stall persists past 100 cycles.

Source files
------------

// File: rtl/amber_wb_arb_pkg.sv
// ----------------------------------------------------------------------------
// amber_wb_arb_pkg
// Shared types and defaults for the two-master Wishbone arbiter.
//   arb_state_t    : arbiter FSM states (idle, owned by m0, owned by m1)
//   AMB_ADDR_W     : default address width
//   AMB_DATA_W     : default data width
//   AMB_TIMEOUT_CYCLES : default watchdog limit (used only when
//                    AMBER_WB_ARB_TIMEOUT_EN is defined)
//   sel_w()        : byte-select width for a given data width
// ----------------------------------------------------------------------------
package amber_wb_arb_pkg;

    localparam int AMB_ADDR_W         = 32;
    localparam int AMB_DATA_W         = 128;
    localparam int AMB_TIMEOUT_CYCLES = 64;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_GNT0 = 2'd1,
        ARB_GNT1 = 2'd2
    } arb_state_t;

    function automatic int sel_w(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/amber_wb_watchdog.sv
// ----------------------------------------------------------------------------
// amber_wb_watchdog
// Counts consecutive cycles in which the current owner is strobing without a
// slave response, and flags expiry on the last allowed cycle.
//   clk    : system clock
//   rst    : asynchronous active-high reset
//   clr    : force the count back to zero (idle or owner change)
//   busy   : stb high with neither ack nor err this cycle
//   expire : count has reached TIMEOUT_CYCLES-1 (the TIMEOUT_CYCLES-th
//            stalled strobe cycle)
// The counter saturates at TIMEOUT_CYCLES so it can never wrap back to an
// apparently healthy value.
// ----------------------------------------------------------------------------
module amber_wb_watchdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic busy,
    output logic expire
);

    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr || !busy) begin
            count_d = '0;
        end else if (count_q != CNT_MAX) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = (count_q == CNT_LAST);

endmodule

// File: rtl/amber_wb_arbiter.sv
// ----------------------------------------------------------------------------
// amber_wb_arbiter
// Two-master Wishbone arbiter in front of the Amber core's single 128-bit
// slave port. Master 0 is the core, master 1 the preload/debug loader.
// A master keeps the bus for as long as it holds cyc; contention from idle
// is resolved round-robin using the last owner.
//
// Ports:
//   clk, rst                    : clock, asynchronous active-high reset
//   m0_* / m1_*  (in)           : adr, sel, we, dat_w, cyc, stb per master
//   m0_* / m1_*  (out)          : dat_r (unqualified copy of s_dat_r),
//                                 ack/err (only to the current owner)
//   s_adr..s_stb (out)          : request of the current owner, 0 when idle
//   s_dat_r, s_ack, s_err (in)  : slave response
//   gnt          (out)          : one-hot owner, 2'b00 when idle
//
// Build option: define AMBER_WB_ARB_TIMEOUT_EN to add a watchdog that errors
// out and releases an owner whose slave has not answered for TIMEOUT_CYCLES
// strobe cycles. Without it a hung slave stalls the owner forever.
// ----------------------------------------------------------------------------
module amber_wb_arbiter
    import amber_wb_arb_pkg::*;
#(
    parameter int ADDR_W         = AMB_ADDR_W,
    parameter int DATA_W         = AMB_DATA_W,
    parameter int TIMEOUT_CYCLES = AMB_TIMEOUT_CYCLES
) (
    input  logic                       clk,
    input  logic                       rst,

    input  logic [ADDR_W-1:0]          m0_adr,
    input  logic [sel_w(DATA_W)-1:0]   m0_sel,
    input  logic                       m0_we,
    input  logic [DATA_W-1:0]          m0_dat_w,
    input  logic                       m0_cyc,
    input  logic                       m0_stb,
    output logic [DATA_W-1:0]          m0_dat_r,
    output logic                       m0_ack,
    output logic                       m0_err,

    input  logic [ADDR_W-1:0]          m1_adr,
    input  logic [sel_w(DATA_W)-1:0]   m1_sel,
    input  logic                       m1_we,
    input  logic [DATA_W-1:0]          m1_dat_w,
    input  logic                       m1_cyc,
    input  logic                       m1_stb,
    output logic [DATA_W-1:0]          m1_dat_r,
    output logic                       m1_ack,
    output logic                       m1_err,

    output logic [ADDR_W-1:0]          s_adr,
    output logic [sel_w(DATA_W)-1:0]   s_sel,
    output logic                       s_we,
    output logic [DATA_W-1:0]          s_dat_w,
    output logic                       s_cyc,
    output logic                       s_stb,
    input  logic [DATA_W-1:0]          s_dat_r,
    input  logic                       s_ack,
    input  logic                       s_err,

    output logic [1:0]                 gnt
);

    arb_state_t state_q;
    arb_state_t state_d;
    logic       last_gnt_q;
    logic       last_gnt_d;

    logic       wd_expire;
    logic       owner_stb;

    // Owner's raw strobe, before any watchdog forcing, so the watchdog input
    // never depends on its own output.
    assign owner_stb = (state_q == ARB_GNT0) ? m0_stb :
                       (state_q == ARB_GNT1) ? m1_stb : 1'b0;

`ifdef AMBER_WB_ARB_TIMEOUT_EN
    logic wd_clr;
    logic wd_busy;

    // Every owner change passes through idle, so clearing in idle and on any
    // state change covers both release and regrant.
    assign wd_clr  = (state_q == ARB_IDLE) || (state_d != state_q);
    assign wd_busy = owner_stb && !s_ack && !s_err;

    amber_wb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (wd_clr),
        .busy   (wd_busy),
        .expire (wd_expire)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0) ^ owner_stb;
    assign wd_expire          = 1'b0;
`endif

    // Next-state, request mux and response demux.
    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        s_adr      = '0;
        s_sel      = '0;
        s_we       = 1'b0;
        s_dat_w    = '0;
        s_cyc      = 1'b0;
        s_stb      = 1'b0;
        m0_ack     = 1'b0;
        m0_err     = 1'b0;
        m1_ack     = 1'b0;
        m1_err     = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                // Late responses arriving here are simply not forwarded.
                if (m0_cyc && m1_cyc) begin
                    state_d = last_gnt_q ? ARB_GNT0 : ARB_GNT1;
                end else if (m0_cyc) begin
                    state_d = ARB_GNT0;
                end else if (m1_cyc) begin
                    state_d = ARB_GNT1;
                end
            end

            ARB_GNT0: begin
                s_adr   = m0_adr;
                s_sel   = m0_sel;
                s_we    = m0_we;
                s_dat_w = m0_dat_w;
                s_cyc   = m0_cyc;
                s_stb   = m0_stb;
                m0_ack  = s_ack;
                m0_err  = s_err;
                if (wd_expire) begin
                    // Kill the slave cycle and error the owner out.
                    s_cyc      = 1'b0;
                    s_stb      = 1'b0;
                    m0_ack     = 1'b0;
                    m0_err     = 1'b1;
                    state_d    = ARB_IDLE;
                    last_gnt_d = 1'b0;
                end else if (!m0_cyc) begin
                    state_d    = ARB_IDLE;
                    last_gnt_d = 1'b0;
                end
            end

            ARB_GNT1: begin
                s_adr   = m1_adr;
                s_sel   = m1_sel;
                s_we    = m1_we;
                s_dat_w = m1_dat_w;
                s_cyc   = m1_cyc;
                s_stb   = m1_stb;
                m1_ack  = s_ack;
                m1_err  = s_err;
                if (wd_expire) begin
                    s_cyc      = 1'b0;
                    s_stb      = 1'b0;
                    m1_ack     = 1'b0;
                    m1_err     = 1'b1;
                    state_d    = ARB_IDLE;
                    last_gnt_d = 1'b1;
                end else if (!m1_cyc) begin
                    state_d    = ARB_IDLE;
                    last_gnt_d = 1'b1;
                end
            end

            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // last_gnt resets to 1 so master 0 wins the first contention.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ARB_IDLE;
            last_gnt_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
        end
    end

    assign m0_dat_r = s_dat_r;
    assign m1_dat_r = s_dat_r;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_gnt
            assign gnt[gi] = (state_q == ((gi == 0) ? ARB_GNT0 : ARB_GNT1));
        end
    endgenerate

endmodule

// File: tb/tb_amber_wb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_amber_wb_arbiter
// Scoreboarded bench for amber_wb_arbiter. Each issued transfer pushes the
// expected (master, read data) pair; a negedge monitor pops it when an ack
// reaches a master. The slave returns a fixed function of s_adr as read data;
// the scenario tasks drive s_ack/s_err themselves.
// ----------------------------------------------------------------------------
module tb_amber_wb_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 128;
    localparam int SEL_W  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [ADDR_W-1:0] m0_adr, m1_adr, s_adr;
    logic [SEL_W-1:0]  m0_sel, m1_sel, s_sel;
    logic              m0_we, m1_we, s_we;
    logic [DATA_W-1:0] m0_dat_w, m1_dat_w, s_dat_w;
    logic              m0_cyc, m1_cyc, s_cyc;
    logic              m0_stb, m1_stb, s_stb;
    logic [DATA_W-1:0] m0_dat_r, m1_dat_r, s_dat_r;
    logic              m0_ack, m1_ack, s_ack;
    logic              m0_err, m1_err, s_err;
    logic [1:0]        gnt;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int                m;
        logic [DATA_W-1:0] dat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    function automatic logic [DATA_W-1:0] mem_val(input logic [ADDR_W-1:0] a);
        return {a, ~a, a ^ 32'h5A5A_5A5A, a + 32'h1};
    endfunction

    assign s_dat_r = mem_val(s_adr);

    amber_wb_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst(rst),
        .m0_adr(m0_adr), .m0_sel(m0_sel), .m0_we(m0_we), .m0_dat_w(m0_dat_w),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_dat_r(m0_dat_r), .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_adr(m1_adr), .m1_sel(m1_sel), .m1_we(m1_we), .m1_dat_w(m1_dat_w),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_dat_r(m1_dat_r), .m1_ack(m1_ack), .m1_err(m1_err),
        .s_adr(s_adr), .s_sel(s_sel), .s_we(s_we), .s_dat_w(s_dat_w),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_dat_r(s_dat_r), .s_ack(s_ack), .s_err(s_err),
        .gnt(gnt)
    );

    // Scoreboard monitor: every ack seen by a master must match the oldest
    // outstanding expectation.
    always @(negedge clk) begin
        if (!rst && (m0_ack || m1_ack)) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected_ack m0_ack=%b m1_ack=%b expected no ack", m0_ack, m1_ack);
            end else begin
                mon_e = sb.pop_front();
                if ((m0_ack && m1_ack) || ((m1_ack ? 1 : 0) != mon_e.m) ||
                    ((m1_ack ? m1_dat_r : m0_dat_r) !== mon_e.dat)) begin
                    bad++;
                    $display("FAIL sb_xfer got m0_ack=%b m1_ack=%b dat=%h expected m%0d dat=%h",
                             m0_ack, m1_ack, (m1_ack ? m1_dat_r : m0_dat_r), mon_e.m, mon_e.dat);
                end else begin
                    $display("xfer m%0d adr=%h we=%b dat_r=%h", mon_e.m, s_adr, s_we, mon_e.dat);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        m0_adr = '0; m0_sel = '0; m0_we = 1'b0; m0_dat_w = '0; m0_cyc = 1'b0; m0_stb = 1'b0;
        m1_adr = '0; m1_sel = '0; m1_we = 1'b0; m1_dat_w = '0; m1_cyc = 1'b0; m1_stb = 1'b0;
        s_ack = 1'b0; s_err = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        idle_inputs();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        total++;
        if (gnt !== 2'b00 || s_cyc !== 1'b0 || s_stb !== 1'b0) begin
            bad++;
            $display("FAIL reset_state gnt=%b s_cyc=%b s_stb=%b expected 00 0 0", gnt, s_cyc, s_stb);
        end
        total++;
        if (m0_ack !== 1'b0 || m1_ack !== 1'b0 || m0_err !== 1'b0 || m1_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_resp acks=%b%b errs=%b%b expected 0000", m0_ack, m1_ack, m0_err, m1_err);
        end
    endtask

    task automatic test_single_read();
        step();
        m0_adr = 32'h100; m0_sel = 16'hFFFF; m0_we = 1'b0; m0_cyc = 1'b1; m0_stb = 1'b1;
        s_ack = 1'b1;   // an ack while idle must not leak to anyone
        #1;
        total++;
        if (s_cyc !== 1'b0 || gnt !== 2'b00 || m0_ack !== 1'b0) begin
            bad++;
            $display("FAIL read_latency s_cyc=%b gnt=%b m0_ack=%b expected 0 00 0", s_cyc, gnt, m0_ack);
        end
        step();
        s_ack = 1'b0;
        #1;
        total++;
        if (s_cyc !== 1'b1 || s_stb !== 1'b1 || s_adr !== 32'h100 || gnt !== 2'b01) begin
            bad++;
            $display("FAIL read_grant s_cyc=%b s_stb=%b s_adr=%h gnt=%b expected 1 1 100 01",
                     s_cyc, s_stb, s_adr, gnt);
        end
        sb.push_back('{0, mem_val(32'h100)});
        s_ack = 1'b1;
        #1;
        total++;
        if (m0_ack !== 1'b1 || m1_ack !== 1'b0) begin
            bad++;
            $display("FAIL read_ack m0_ack=%b m1_ack=%b expected 1 0", m0_ack, m1_ack);
        end
        step();
        s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
        step();
        #1;
        total++;
        if (gnt !== 2'b00 || s_cyc !== 1'b0) begin
            bad++;
            $display("FAIL read_release gnt=%b s_cyc=%b expected 00 0", gnt, s_cyc);
        end
    endtask

    task automatic test_contention();
        apply_reset();
        m0_adr = 32'h200; m0_sel = 16'hFFFF; m0_cyc = 1'b1; m0_stb = 1'b1;
        m1_adr = 32'h300; m1_sel = 16'hFFFF; m1_cyc = 1'b1; m1_stb = 1'b1;
        step();
        #1;
        total++;
        if (gnt !== 2'b01 || s_adr !== 32'h200) begin
            bad++;
            $display("FAIL contend_first gnt=%b s_adr=%h expected 01 200", gnt, s_adr);
        end
        sb.push_back('{0, mem_val(32'h200)});
        s_ack = 1'b1;
        step();
        s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
        step();
        #1;
        total++;
        if (gnt !== 2'b00 || s_cyc !== 1'b0) begin
            bad++;
            $display("FAIL contend_gap gnt=%b s_cyc=%b expected 00 0", gnt, s_cyc);
        end
        step();
        #1;
        total++;
        if (gnt !== 2'b10 || s_adr !== 32'h300) begin
            bad++;
            $display("FAIL contend_second gnt=%b s_adr=%h expected 10 300", gnt, s_adr);
        end
        sb.push_back('{1, mem_val(32'h300)});
        s_ack = 1'b1;
        step();
        s_ack = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        m1_adr = 32'h400; m1_sel = 16'hFFFF; m1_cyc = 1'b1; m1_stb = 1'b1;
        step();
        m0_adr = 32'h500; m0_sel = 16'hFFFF; m0_cyc = 1'b1; m0_stb = 1'b1;
        for (int i = 0; i < 4; i++) begin
            m1_adr = 32'h400 + 32'(16 * i);
            sb.push_back('{1, mem_val(m1_adr)});
            s_ack = 1'b1;
            #1;
            total++;
            if (gnt !== 2'b10 || m0_ack !== 1'b0 || m1_ack !== 1'b1) begin
                bad++;
                $display("FAIL burst_beat%0d gnt=%b m0_ack=%b m1_ack=%b expected 10 0 1",
                         i, gnt, m0_ack, m1_ack);
            end
            step();
        end
        s_ack = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
        step();
        #1;
        total++;
        if (gnt !== 2'b00 || m0_ack !== 1'b0) begin
            bad++;
            $display("FAIL burst_gap gnt=%b m0_ack=%b expected 00 0", gnt, m0_ack);
        end
        step();
        #1;
        total++;
        if (gnt !== 2'b01 || s_adr !== 32'h500) begin
            bad++;
            $display("FAIL burst_m0_after gnt=%b s_adr=%h expected 01 500", gnt, s_adr);
        end
        sb.push_back('{0, mem_val(32'h500)});
        s_ack = 1'b1;
        step();
        s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
        step();
    endtask

    task automatic test_abort();
        m1_adr = 32'h600; m1_sel = 16'hFFFF; m1_cyc = 1'b1; m1_stb = 1'b1;
        step();
        step();
        m1_cyc = 1'b0; m1_stb = 1'b0;
        step();
        s_ack = 1'b1;
        #1;
        total++;
        if (gnt !== 2'b00 || m0_ack !== 1'b0 || m1_ack !== 1'b0 || s_cyc !== 1'b0) begin
            bad++;
            $display("FAIL abort_late_ack gnt=%b m0_ack=%b m1_ack=%b s_cyc=%b expected 00 0 0 0",
                     gnt, m0_ack, m1_ack, s_cyc);
        end
        step();
        s_ack = 1'b0;
    endtask

    task automatic test_write();
        logic [DATA_W-1:0] val;
        logic [SEL_W-1:0]  sels [2];
        logic [DATA_W-1:0] mask;
        val = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_DEAD_BEEF;
        sels[0] = 16'hFFFF;
        sels[1] = 16'h00F0;
        for (int t = 0; t < 2; t++) begin
            m0_adr = 32'h700 + 32'(t * 16); m0_sel = sels[t]; m0_we = 1'b1;
            m0_dat_w = val; m0_cyc = 1'b1; m0_stb = 1'b1;
            step();
            mask = '0;
            for (int b = 0; b < SEL_W; b++) begin
                if (sels[t][b]) mask[b*8 +: 8] = 8'hFF;
            end
            #1;
            total++;
            if (s_we !== 1'b1 || s_sel !== sels[t] || (s_dat_w & mask) !== (val & mask)) begin
                bad++;
                $display("FAIL write%0d s_we=%b s_sel=%h s_dat_w=%h expected 1 %h %h (masked)",
                         t, s_we, s_sel, s_dat_w, sels[t], val & mask);
            end
            sb.push_back('{0, mem_val(m0_adr)});
            s_ack = 1'b1;
            step();
            s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0;
            step();
        end
    endtask

    task automatic test_ack_err();
        m0_adr = 32'h800; m0_sel = 16'hFFFF; m0_cyc = 1'b1; m0_stb = 1'b1;
        step();
        sb.push_back('{0, mem_val(32'h800)});
        s_ack = 1'b1; s_err = 1'b1;
        #1;
        total++;
        if (m0_ack !== 1'b1 || m0_err !== 1'b1 || m1_err !== 1'b0 || m1_ack !== 1'b0) begin
            bad++;
            $display("FAIL ack_err m0_ack=%b m0_err=%b m1_ack=%b m1_err=%b expected 1 1 0 0",
                     m0_ack, m0_err, m1_ack, m1_err);
        end
        step();
        s_ack = 1'b0; s_err = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
        step();
    endtask

    task automatic test_timeout();
        m0_adr = 32'h900; m0_sel = 16'hFFFF; m0_cyc = 1'b1; m0_stb = 1'b1;
        step();
`ifdef AMBER_WB_ARB_TIMEOUT_EN
        for (int k = 1; k <= 8; k++) begin
            #1;
            total++;
            if (k < 8) begin
                if (m0_err !== 1'b0 || s_cyc !== 1'b1 || gnt !== 2'b01) begin
                    bad++;
                    $display("FAIL timeout_wait%0d m0_err=%b s_cyc=%b gnt=%b expected 0 1 01",
                             k, m0_err, s_cyc, gnt);
                end
            end else begin
                if (m0_err !== 1'b1 || s_cyc !== 1'b0 || s_stb !== 1'b0) begin
                    bad++;
                    $display("FAIL timeout_fire m0_err=%b s_cyc=%b s_stb=%b expected 1 0 0",
                             m0_err, s_cyc, s_stb);
                end
            end
            step();
        end
        m0_cyc = 1'b0; m0_stb = 1'b0;
        #1;
        total++;
        if (gnt !== 2'b00 || m0_err !== 1'b0) begin
            bad++;
            $display("FAIL timeout_after gnt=%b m0_err=%b expected 00 0", gnt, m0_err);
        end
`else
        begin
            int stalled = 0;
            for (int k = 0; k < 105; k++) begin
                #1;
                if (s_cyc === 1'b1 && gnt === 2'b01 && m0_err === 1'b0 && m0_ack === 1'b0)
                    stalled++;
                step();
            end
            total++;
            if (stalled !== 105) begin
                bad++;
                $display("FAIL stall_persist stalled_cycles=%0d expected 105", stalled);
            end
        end
        m0_cyc = 1'b0; m0_stb = 1'b0;
`endif
        step();
        step();
    endtask

    task automatic test_async_reset();
        m1_adr = 32'hA00; m1_sel = 16'hFFFF; m1_cyc = 1'b1; m1_stb = 1'b1;
        step();
        #1;
        total++;
        if (gnt !== 2'b10 || s_cyc !== 1'b1) begin
            bad++;
            $display("FAIL arst_pre gnt=%b s_cyc=%b expected 10 1", gnt, s_cyc);
        end
        rst = 1'b1;
        #1;
        total++;
        if (gnt !== 2'b00 || s_cyc !== 1'b0 || s_stb !== 1'b0) begin
            bad++;
            $display("FAIL arst_immediate gnt=%b s_cyc=%b s_stb=%b expected 00 0 0", gnt, s_cyc, s_stb);
        end
        idle_inputs();
        step();
        rst = 1'b0;
        // Round-robin state must be back to favouring master 0.
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'hB00;
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 32'hC00;
        step();
        #1;
        total++;
        if (gnt !== 2'b01) begin
            bad++;
            $display("FAIL arst_rr gnt=%b expected 01", gnt);
        end
        m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
        step();
        step();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_read();
        test_contention();
        test_back_to_back();
        test_abort();
        test_write();
        test_ack_err();
        test_timeout();
        test_async_reset();
        total++;
        if (sb.size() !== 0) begin
            bad++;
            $display("FAIL sb_drain outstanding=%0d expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
